light_safety_monitor: RTL and testbench
=======================================

# light_safety_monitor

Conflict monitor and lamp driver. Sits directly downstream of the four-phase intersection controller: takes its six raw lamp signals plus the shared 1 Hz `tick`, and checks every cycle for illegal lamp combinations, illegal sequences and short phases. It forwards legal lamp states to the lamp drivers with one cycle of latency. On the first violation it latches a fault, switches the lamps to flashing yellow, and resynchronises to the controller only after an explicit clear.

## Interface
- `GREEN_MIN_TICKS`, 5: minimum ticks a green must be held before going yellow.
- `YELLOW_MIN_TICKS`, 2: minimum ticks a yellow must be held before going red.
- `FLASH_HALF_TICKS`, 1: ticks per on or off half-period of the fault flash.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: one-cycle 1 Hz pulse, the same pulse the controller uses.
- `ns_g_in`, `ns_y_in`, `ns_r_in`, `ew_g_in`, `ew_y_in`, `ew_r_in` in 1 each: raw controller lamp outputs.
- `clear_fault` in 1: level; acknowledges a latched fault.
- `ns_g`, `ns_y`, `ns_r`, `ew_g`, `ew_y`, `ew_r` out 1 each: registered lamp drives.
- `fault` out 1: registered fault flag.
- `fault_code` out 3: code of the most recent fault.
- `fault_count` out 8: number of fault entries, saturating.

## Operation
- Reset values:
  - lamps: `ns_r`=`ew_r`=1, all other lamps 0.
  - `fault`=0, `fault_code`=0, `fault_count`=0.
  - state MON.
  - previous-lamp register = NS green / EW red.
  - tick counters = 0.
- States:
  - MON: checks enabled; lamp outputs = inputs registered.
  - FLASH: checks disabled; `ns_y`=`ew_y`=flash phase; all other lamps 0; phase starts on and toggles after every `FLASH_HALF_TICKS` ticks.
  - RESYNC: checks disabled; all red.
- Checks in MON, evaluated on the current inputs against the previous-lamp register. The lowest code wins on simultaneous violations.
  - 1 ILLEGAL_COMBO: a direction does not have exactly one lamp set.
  - 2 CONFLICT: both directions are non-red.
  - 3 BAD_SEQ: a direction's lamp changed other than G→Y, Y→R or R→G.
  - 4 SHORT_YELLOW: Y→R with the yellow tick counter below `YELLOW_MIN_TICKS`.
  - 5 SHORT_GREEN: G→Y with the green tick counter below `GREEN_MIN_TICKS`.
- Per-direction tick counters (4 bits, saturating at 15):
  - increment on `tick` while that direction's lamp is unchanged from the previous cycle;
  - reload to `tick` (0 or 1) on a lamp change.
- MON→FLASH on any violation. Effects on the next edge:
  - `fault`=1;
  - `fault_code` loaded;
  - `fault_count`+1, saturating at 255;
  - lamps = both yellow on.
- FLASH→RESYNC when `clear_fault`=1. `clear_fault` is ignored in MON and RESYNC.
- RESYNC→MON on the cycle the inputs show NS green / EW red while the previous-lamp register held EW yellow. In that cycle:
  - counters reload with `tick`;
  - `fault`=0 on the next edge;
  - `fault_code` retained.
- The previous-lamp register updates from the inputs every cycle, in every state.

## Timing
- Lamp latency in MON: 1 cycle, from input to output.
- Fault detection: violation on inputs at edge N gives `fault`, `fault_code` and flash lamps at edge N+1. The offending lamp value never reaches the outputs.
- `tick` and `clear_fault` in the same cycle in FLASH: the clear wins; the flash phase is discarded.
- Flash phase resets to on at every entry into FLASH.
- `rst` mid-FLASH or mid-RESYNC:
  - returns to MON with the reset values;
  - `fault_count` and `fault_code` clear.
- The controller and monitor must be reset together. The first NS green after reset counts the tick present in the reset-release cycle onward.

## Configuration
- `LSM_TIMING_CHECK_EN` defined: tick counters and checks 4 and 5 are compiled in.
- `LSM_TIMING_CHECK_EN` undefined:
  - counters are removed; only checks 1–3 run;
  - `GREEN_MIN_TICKS` and `YELLOW_MIN_TICKS` are accepted but unused;
  - `FLASH_HALF_TICKS` is unaffected.

## Test plan
- Legal cycle, defaults. Reset, then 2 full controller cycles (5/2/5/2 ticks, `tick` every 4 clks) → lamps mirror inputs delayed 1 clk; `fault`=0 and `fault_count`=0 throughout.
- Conflict. Drive `ns_g_in`=`ew_g_in`=1, both reds 0, for 1 clk in MON → next edge: `fault`=1, `fault_code`=2, `ns_y`=`ew_y`=1, other lamps 0, `fault_count`=1.
- Priority and sequence. Drive `ns_g_in`=`ns_y_in`=1 with `ew_g_in`=1 → `fault_code`=1. Separately, NS green→red directly with EW red held → `fault_code`=3.
- Short yellow. EW yellow held 1 tick then red:
  - with `LSM_TIMING_CHECK_EN` → `fault_code`=4;
  - without it → `fault`=0, lamps mirror.
- Flash and recovery, `FLASH_HALF_TICKS`=1:
  - in FLASH, yellows toggle on each tick, starting on;
  - assert `clear_fault` coincident with `tick` → all red next edge, no toggle;
  - all red holds mid-NS-green;
  - on the EW yellow → NS green/EW red transition → MON, `fault`=0, `fault_code` unchanged.
- Saturation and reset. 256 fault/clear/resync loops → `fault_count`=255. Then `rst` in FLASH → all red, counters 0, MON.

Source files
------------

// File: rtl/light_safety_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | light_safety_monitor: lamp conflict/sequence monitor with fault flash.   |
// | Optional macro LSM_TIMING_CHECK_EN adds tick counters and phase checks.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module light_safety_monitor #(
    parameter int GREEN_MIN_TICKS  = 5,
    parameter int YELLOW_MIN_TICKS = 2,
    parameter int FLASH_HALF_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ns_g_in,
    input  logic       ns_y_in,
    input  logic       ns_r_in,
    input  logic       ew_g_in,
    input  logic       ew_y_in,
    input  logic       ew_r_in,
    input  logic       clear_fault,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count
);

    localparam logic [2:0] c_green  = 3'b100;
    localparam logic [2:0] c_yellow = 3'b010;
    localparam logic [2:0] c_red    = 3'b001;

    localparam logic [2:0] c_code_combo     = 3'd1;
    localparam logic [2:0] c_code_conflict  = 3'd2;
    localparam logic [2:0] c_code_bad_seq   = 3'd3;
    localparam logic [2:0] c_code_short_yel = 3'd4;
    localparam logic [2:0] c_code_short_grn = 3'd5;

    localparam int FLASH_W = (FLASH_HALF_TICKS > 1) ? $clog2(FLASH_HALF_TICKS) : 1;
    localparam logic [FLASH_W-1:0] c_flash_last = FLASH_W'(FLASH_HALF_TICKS - 1);

    typedef enum logic [1:0] {
        S_MON    = 2'd0,
        S_FLASH  = 2'd1,
        S_RESYNC = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [2:0]         w_ns_in, w_ew_in;
    logic [2:0]         r_prev_ns, r_prev_ew;
    logic [2:0]         r_ns_lamp, r_ew_lamp, w_ns_lamp_next, w_ew_lamp_next;
    logic               r_fault, w_fault_next;
    logic [2:0]         r_code, w_code_next;
    logic [7:0]         r_count, w_count_next;
    logic               r_flash_phase, w_flash_phase_next;
    logic [FLASH_W-1:0] r_flash_cnt, w_flash_cnt_next;
    logic               w_combo_bad, w_conflict, w_bad_seq;
    logic               w_short_yellow, w_short_green;
    logic               w_violation, w_resync_done;
    logic [2:0]         w_viol_code;

    assign w_ns_in = {ns_g_in, ns_y_in, ns_r_in};
    assign w_ew_in = {ew_g_in, ew_y_in, ew_r_in};

    function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
        return (cur == prev)
            || (prev == c_green  && cur == c_yellow)
            || (prev == c_yellow && cur == c_red)
            || (prev == c_red    && cur == c_green);
    endfunction

    assign w_combo_bad   = !$onehot(w_ns_in) || !$onehot(w_ew_in);
    assign w_conflict    = !ns_r_in && !ew_r_in;
    assign w_bad_seq     = !legal_step(r_prev_ns, w_ns_in) || !legal_step(r_prev_ew, w_ew_in);
    assign w_violation   = w_combo_bad || w_conflict || w_bad_seq || w_short_yellow || w_short_green;
    // Controller has just started a fresh NS green after the EW yellow ended.
    assign w_resync_done = (w_ns_in == c_green) && (w_ew_in == c_red) && (r_prev_ew == c_yellow);

`ifdef LSM_TIMING_CHECK_EN
    localparam logic [3:0] c_green_min  = (GREEN_MIN_TICKS  > 15) ? 4'd15 : 4'(GREEN_MIN_TICKS);
    localparam logic [3:0] c_yellow_min = (YELLOW_MIN_TICKS > 15) ? 4'd15 : 4'(YELLOW_MIN_TICKS);

    logic [3:0] r_ns_cnt, r_ew_cnt;

    function automatic logic [3:0] cnt_next(input logic [2:0] prev, input logic [2:0] cur,
                                            input logic [3:0] cnt, input logic t);
        if (cur != prev)
            return {3'b000, t};
        if (t && cnt != 4'd15)
            return cnt + 4'd1;
        return cnt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ns_cnt <= '0;
            r_ew_cnt <= '0;
        end else if (r_state == S_RESYNC && w_resync_done) begin
            r_ns_cnt <= {3'b000, tick};
            r_ew_cnt <= {3'b000, tick};
        end else begin
            r_ns_cnt <= cnt_next(r_prev_ns, w_ns_in, r_ns_cnt, tick);
            r_ew_cnt <= cnt_next(r_prev_ew, w_ew_in, r_ew_cnt, tick);
        end
    end

    assign w_short_yellow = (r_prev_ns == c_yellow && w_ns_in == c_red && r_ns_cnt < c_yellow_min)
                         || (r_prev_ew == c_yellow && w_ew_in == c_red && r_ew_cnt < c_yellow_min);
    assign w_short_green  = (r_prev_ns == c_green && w_ns_in == c_yellow && r_ns_cnt < c_green_min)
                         || (r_prev_ew == c_green && w_ew_in == c_yellow && r_ew_cnt < c_green_min);
`else
    // Without the counters the phase limits are accepted but never enforced.
    if (GREEN_MIN_TICKS > 0 || YELLOW_MIN_TICKS > 0) begin : g_timing_unchecked
        assign w_short_yellow = 1'b0;
        assign w_short_green  = 1'b0;
    end else begin : g_timing_trivial
        assign w_short_yellow = 1'b0;
        assign w_short_green  = 1'b0;
    end
`endif

    always_comb begin
        w_viol_code = 3'd0;
        if (w_combo_bad)
            w_viol_code = c_code_combo;
        else if (w_conflict)
            w_viol_code = c_code_conflict;
        else if (w_bad_seq)
            w_viol_code = c_code_bad_seq;
        else if (w_short_yellow)
            w_viol_code = c_code_short_yel;
        else if (w_short_green)
            w_viol_code = c_code_short_grn;
    end

    always_comb begin
        w_state_next       = r_state;
        w_ns_lamp_next     = c_red;
        w_ew_lamp_next     = c_red;
        w_fault_next       = r_fault;
        w_code_next        = r_code;
        w_count_next       = r_count;
        w_flash_phase_next = r_flash_phase;
        w_flash_cnt_next   = r_flash_cnt;
        unique case (r_state)
            S_MON: begin
                if (w_violation) begin
                    w_state_next       = S_FLASH;
                    w_fault_next       = 1'b1;
                    w_code_next        = w_viol_code;
                    w_count_next       = (r_count == 8'hFF) ? 8'hFF : r_count + 8'd1;
                    w_flash_phase_next = 1'b1;
                    w_flash_cnt_next   = '0;
                    w_ns_lamp_next     = c_yellow;
                    w_ew_lamp_next     = c_yellow;
                end else begin
                    w_ns_lamp_next = w_ns_in;
                    w_ew_lamp_next = w_ew_in;
                end
            end
            S_FLASH: begin
                if (clear_fault) begin
                    w_state_next = S_RESYNC;
                end else begin
                    if (tick) begin
                        if (r_flash_cnt == c_flash_last) begin
                            w_flash_phase_next = !r_flash_phase;
                            w_flash_cnt_next   = '0;
                        end else begin
                            w_flash_cnt_next = r_flash_cnt + FLASH_W'(1);
                        end
                    end
                    w_ns_lamp_next = {1'b0, w_flash_phase_next, 1'b0};
                    w_ew_lamp_next = {1'b0, w_flash_phase_next, 1'b0};
                end
            end
            S_RESYNC: begin
                if (w_resync_done) begin
                    w_state_next   = S_MON;
                    w_fault_next   = 1'b0;
                    w_ns_lamp_next = w_ns_in;
                    w_ew_lamp_next = w_ew_in;
                end
            end
            default: w_state_next = S_MON;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_MON;
            r_ns_lamp     <= c_red;
            r_ew_lamp     <= c_red;
            r_fault       <= 1'b0;
            r_code        <= 3'd0;
            r_count       <= 8'd0;
            r_prev_ns     <= c_green;
            r_prev_ew     <= c_red;
            r_flash_phase <= 1'b1;
            r_flash_cnt   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_ns_lamp     <= w_ns_lamp_next;
            r_ew_lamp     <= w_ew_lamp_next;
            r_fault       <= w_fault_next;
            r_code        <= w_code_next;
            r_count       <= w_count_next;
            r_prev_ns     <= w_ns_in;
            r_prev_ew     <= w_ew_in;
            r_flash_phase <= w_flash_phase_next;
            r_flash_cnt   <= w_flash_cnt_next;
        end
    end

    assign {ns_g, ns_y, ns_r} = r_ns_lamp;
    assign {ew_g, ew_y, ew_r} = r_ew_lamp;
    assign fault              = r_fault;
    assign fault_code         = r_code;
    assign fault_count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_light_safety_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_light_safety_monitor: directed scoreboard bench for the lamp monitor. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_light_safety_monitor;

    localparam logic [2:0]  G   = 3'b100;
    localparam logic [2:0]  Y   = 3'b010;
    localparam logic [2:0]  R   = 3'b001;
    localparam logic [2:0]  OFF = 3'b000;
    localparam logic [17:0] ALL      = 18'h3FFFF;
    localparam logic [17:0] NO_LAMPS = 18'h00FFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ns_g_in, ns_y_in, ns_r_in, ew_g_in, ew_y_in, ew_r_in;
    logic       clear_fault;
    logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_count;

    typedef struct {
        logic [17:0] exp;
        logic [17:0] mask;
        string       tag;
    } sb_t;

    sb_t        sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [2:0] exp_code = 3'd0;
    int         exp_cnt  = 0;

    light_safety_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .ns_g_in     (ns_g_in),
        .ns_y_in     (ns_y_in),
        .ns_r_in     (ns_r_in),
        .ew_g_in     (ew_g_in),
        .ew_y_in     (ew_y_in),
        .ew_r_in     (ew_r_in),
        .clear_fault (clear_fault),
        .ns_g        (ns_g),
        .ns_y        (ns_y),
        .ns_r        (ns_r),
        .ew_g        (ew_g),
        .ew_y        (ew_y),
        .ew_r        (ew_r),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_count (fault_count)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] ev(input logic [2:0] ns3, input logic [2:0] ew3,
                                       input logic f, input logic [2:0] code, input logic [7:0] cnt);
        return {ns3, ew3, f, code, cnt};
    endfunction

    // One clock: drive inputs, queue the expected post-edge outputs, then check them.
    task automatic step(input logic [2:0] ns3, input logic [2:0] ew3, input logic t,
                        input logic clr, input logic [17:0] exp, input logic [17:0] mask,
                        input string tag);
        sb_t         e;
        logic [17:0] obs;
        @(negedge clk);
        {ns_g_in, ns_y_in, ns_r_in} = ns3;
        {ew_g_in, ew_y_in, ew_r_in} = ew3;
        tick        = t;
        clear_fault = clr;
        sb.push_back('{exp, mask, tag});
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        obs = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, fault, fault_code, fault_count};
        total++;
        assert ((obs & e.mask) === (e.exp & e.mask)) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs & e.mask, e.exp & e.mask);
        end
    endtask

    // Legal controller phase: held for n ticks, tick on the 4th clock of each group.
    task automatic run_phase(input logic [2:0] ns3, input logic [2:0] ew3, input int n);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < 4; j++)
                step(ns3, ew3, (j == 3), 1'b0, ev(ns3, ew3, 1'b0, exp_code, 8'(exp_cnt)), ALL, "mirror");
    endtask

    task automatic fault_in(input logic [2:0] ns3, input logic [2:0] ew3,
                            input logic [2:0] code, input string tag);
        exp_code = code;
        if (exp_cnt < 255)
            exp_cnt++;
        step(ns3, ew3, 1'b0, 1'b0, ev(Y, Y, 1'b1, exp_code, 8'(exp_cnt)), ALL, tag);
    endtask

    task automatic recover();
        step(R, Y, 1'b0, 1'b1, ev(R, R, 1'b1, exp_code, 8'(exp_cnt)), ALL, "clear");
        step(G, R, 1'b0, 1'b0, ev(R, R, 1'b0, exp_code, 8'(exp_cnt)), NO_LAMPS, "resync_exit");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        clear_fault = 1'b0;
        {ns_g_in, ns_y_in, ns_r_in} = G;
        {ew_g_in, ew_y_in, ew_r_in} = R;

        step(G, R, 1'b0, 1'b0, ev(R, R, 1'b0, 3'd0, 8'd0), ALL, "reset");
        step(G, G, 1'b1, 1'b1, ev(R, R, 1'b0, 3'd0, 8'd0), ALL, "reset_ignores_inputs");
        step(G, R, 1'b0, 1'b0, ev(R, R, 1'b0, 3'd0, 8'd0), ALL, "reset_hold");
        rst = 1'b0;

        for (int c = 0; c < 2; c++) begin
            run_phase(G, R, 5);
            run_phase(Y, R, 2);
            run_phase(R, G, 5);
            run_phase(R, Y, 2);
        end

        fault_in(G, G, 3'd2, "conflict");
        step(R, G, 1'b0, 1'b0, ev(Y, Y, 1'b1, exp_code, 8'(exp_cnt)), ALL, "flash_on_hold");
        step(R, G, 1'b1, 1'b0, ev(OFF, OFF, 1'b1, exp_code, 8'(exp_cnt)), ALL, "flash_tick_off");
        step(R, G, 1'b0, 1'b0, ev(OFF, OFF, 1'b1, exp_code, 8'(exp_cnt)), ALL, "flash_off_hold");
        step(R, G, 1'b1, 1'b0, ev(Y, Y, 1'b1, exp_code, 8'(exp_cnt)), ALL, "flash_tick_on");
        step(R, G, 1'b1, 1'b1, ev(R, R, 1'b1, exp_code, 8'(exp_cnt)), ALL, "clear_with_tick");
        step(G, R, 1'b0, 1'b0, ev(R, R, 1'b1, exp_code, 8'(exp_cnt)), ALL, "resync_mid_green");
        step(G, R, 1'b1, 1'b1, ev(R, R, 1'b1, exp_code, 8'(exp_cnt)), ALL, "resync_hold_tick");
        step(G, R, 1'b0, 1'b0, ev(R, R, 1'b1, exp_code, 8'(exp_cnt)), ALL, "resync_hold");
        step(R, Y, 1'b0, 1'b0, ev(R, R, 1'b1, exp_code, 8'(exp_cnt)), ALL, "resync_ew_yellow");
        step(G, R, 1'b0, 1'b0, ev(R, R, 1'b0, 3'd2, 8'd1), NO_LAMPS, "resync_to_mon");
        step(G, R, 1'b0, 1'b0, ev(G, R, 1'b0, 3'd2, 8'd1), ALL, "mon_after_resync");

        run_phase(G, R, 5);
        run_phase(Y, R, 2);
        run_phase(R, G, 5);
        run_phase(R, Y, 1);
`ifdef LSM_TIMING_CHECK_EN
        fault_in(G, R, 3'd4, "short_yellow");
        recover();
`else
        step(G, R, 1'b0, 1'b0, ev(G, R, 1'b0, exp_code, 8'(exp_cnt)), ALL, "short_yellow_ignored");
`endif

        fault_in(3'b110, G, 3'd1, "combo_priority");
        recover();
        fault_in(R, R, 3'd3, "bad_seq_g_to_r");
        recover();

        for (int i = 0; i < 256; i++) begin
            fault_in(G, G, 3'd2, "sat_fault");
            recover();
        end
        fault_in(G, G, 3'd2, "sat_hold_255");

        rst = 1'b1;
        exp_code = 3'd0;
        exp_cnt  = 0;
        step(G, R, 1'b0, 1'b0, ev(R, R, 1'b0, 3'd0, 8'd0), ALL, "rst_in_flash");
        rst = 1'b0;
        step(G, R, 1'b0, 1'b0, ev(G, R, 1'b0, 3'd0, 8'd0), ALL, "mon_after_rst");
        step(G, R, 1'b1, 1'b1, ev(G, R, 1'b0, 3'd0, 8'd0), ALL, "mon_clear_ignored");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
